pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_pkg.sv | 12 +
 rtl/pipe_adder_add_slice.sv | 14 +
 rtl/pipe_adder.sv | 107 ++++++++++
 tb/tb_pipe_adder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared types and default geometry for the pipelined wide adder/subtractor.
package pipe_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 100;
    localparam int unsigned DEFAULT_STAGES = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/pipe_adder_add_slice.sv
// Combinational SLICE-bit adder used by each pipeline stage.
module add_slice #(
    parameter int unsigned SLICE = 25
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = (SLICE+1)'(a) + (SLICE+1)'(b) + (SLICE+1)'(cin);

endmodule

// File: rtl/pipe_adder.sv
// Streaming add/sub split into STAGES carry-chained slices; a whole-pipe stall
// freezes every stage while the result at the output is not taken.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  op_e              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned SLICE = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

    if ((WIDTH % STAGES) != 0) begin : g_width_check
        $error("pipe_adder: WIDTH must be an integer multiple of STAGES");
    end

    // Operands shift down by SLICE per stage; the sum fills in from the top.
    logic [WIDTH-1:0]  r_a [STAGES];
    logic [WIDTH-1:0]  r_b [STAGES];
    logic [WIDTH-1:0]  r_s [STAGES];
    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_c;
    logic              r_ovf;

    logic [WIDTH-1:0]  w_a_in [STAGES];
    logic [WIDTH-1:0]  w_b_in [STAGES];
    logic [WIDTH-1:0]  w_s_in [STAGES];
    logic [SLICE-1:0]  w_slice_sum [STAGES];
    logic [STAGES-1:0] w_c_in;
    logic [STAGES-1:0] w_v_in;
    logic [STAGES-1:0] w_slice_co;
    logic              w_stall;
    logic              w_ovf;

    assign w_stall = r_v[LAST] && !out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_a_in[k] = a;
            assign w_b_in[k] = (op == OP_SUB) ? ~b : b;
            assign w_c_in[k] = (op == OP_SUB) ? ~cin : cin;
            assign w_v_in[k] = in_valid;
            assign w_s_in[k] = '0;
        end else begin : g_chain
            assign w_a_in[k] = r_a[k-1];
            assign w_b_in[k] = r_b[k-1];
            assign w_c_in[k] = r_c[k-1];
            assign w_v_in[k] = r_v[k-1];
            assign w_s_in[k] = r_s[k-1];
        end

        add_slice #(
            .SLICE(SLICE)
        ) u_slice (
            .a    (w_a_in[k][SLICE-1:0]),
            .b    (w_b_in[k][SLICE-1:0]),
            .cin  (w_c_in[k]),
            .sum  (w_slice_sum[k]),
            .cout (w_slice_co[k])
        );
    end

    // Signed overflow from the effective addend MSBs seen by the last slice.
    assign w_ovf = (w_a_in[LAST][SLICE-1] == w_b_in[LAST][SLICE-1]) &&
                   (w_slice_sum[LAST][SLICE-1] != w_a_in[LAST][SLICE-1]);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_v   <= '0;
            r_c   <= '0;
            r_ovf <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_s[k] <= '0;
            end
        end else if (!w_stall) begin
            r_v   <= w_v_in;
            r_c   <= w_slice_co;
            r_ovf <= w_ovf;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= w_a_in[k] >> SLICE;
                r_b[k] <= w_b_in[k] >> SLICE;
                r_s[k] <= (w_s_in[k] >> SLICE) | (WIDTH'(w_slice_sum[k]) << (WIDTH - SLICE));
            end
        end
    end

    assign in_ready  = !w_stall;
    assign out_valid = r_v[LAST];
    assign sum       = r_s[LAST];
    assign cout      = r_c[LAST];
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipe_adder.sv
// Randomised and directed bench for pipe_adder against an arithmetic scoreboard.
module tb_pipe_adder;
    import pipe_adder_pkg::*;

    localparam int unsigned W = 100;
    localparam int unsigned S = 4;

    logic         clk = 1'b0;
    logic         resetn;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    op_e          op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    pipe_adder #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc_cyc;
        int           acc_stalls;
    } exp_t;

    exp_t         q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           n_stall = 0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic         prev_ovf;
    bit           use_const = 1'b0;
    logic [W-1:0] c_sum;
    logic         c_cout;
    logic         c_ovf;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Exact integer arithmetic: unsigned result for sum/cout, signed range test for ovf.
    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic ic, input op_e iop);
        exp_t                 e;
        logic [W:0]           wide;
        logic signed [W+1:0]  sa, sb, ex;
        sa = $signed({{2{ia[W-1]}}, ia});
        sb = $signed({{2{ib[W-1]}}, ib});
        if (iop == OP_ADD) begin
            wide   = {1'b0, ia} + {1'b0, ib} + (W+1)'(ic);
            e.cout = wide[W];
            ex     = sa + sb + $signed((W+2)'(ic));
        end else begin
            wide   = {1'b0, ia} - {1'b0, ib} - (W+1)'(ic);
            e.cout = ({1'b0, ia} >= ({1'b0, ib} + (W+1)'(ic)));
            ex     = sa - sb - $signed((W+2)'(ic));
        end
        e.sum = wide[W-1:0];
        e.ovf = (ex[W+1:W-1] != {3{ex[W-1]}});
        e.acc_cyc    = 0;
        e.acc_stalls = 0;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return r[W-1:0];
        endcase
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input op_e iop);
        in_valid = v;
        a        = ia;
        b        = ib;
        cin      = ic;
        op       = iop;
    endtask

    task automatic drive_rand(input logic v);
        drive(v, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) == 1) ? OP_SUB : OP_ADD);
    endtask

    // One cycle: sample mid-low-phase, score the handshakes, advance to next negedge.
    task automatic tick();
        exp_t e;
        bit   stall_now;
        #1;
        stall_now = 1'b0;
        if (!resetn) begin
            q.delete();
        end else begin
            if (out_valid === 1'b1 && q.size() == 0) begin
                check("spurious_valid", 128'(out_valid), 128'(0));
            end else if (out_valid === 1'b1 && out_ready) begin
                e = q.pop_front();
                check("sum",     128'(sum),  128'(e.sum));
                check("cout",    128'(cout), 128'(e.cout));
                check("ovf",     128'(ovf),  128'(e.ovf));
                check("latency", 128'(cyc - e.acc_cyc), 128'(S + n_stall - e.acc_stalls));
            end
            if (out_valid === 1'b1 && !out_ready) begin
                stall_now = 1'b1;
                check("stall_in_ready", 128'(in_ready), 128'(0));
                if (prev_stall) begin
                    check("stall_hold_sum",  128'(sum),  128'(prev_sum));
                    check("stall_hold_cout", 128'(cout), 128'(prev_cout));
                    check("stall_hold_ovf",  128'(ovf),  128'(prev_ovf));
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                if (use_const) begin
                    e.sum  = c_sum;
                    e.cout = c_cout;
                    e.ovf  = c_ovf;
                end else begin
                    e = model(a, b, cin, op);
                end
                e.acc_cyc    = cyc;
                e.acc_stalls = n_stall;
                q.push_back(e);
            end
        end
        if (stall_now) n_stall++;
        prev_stall = stall_now;
        prev_sum   = sum;
        prev_cout  = cout;
        prev_ovf   = ovf;
        cyc++;
        @(negedge clk);
    endtask

    task automatic directed(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                            input op_e iop, input logic [W-1:0] es, input logic ec,
                            input logic eo);
        use_const = 1'b1;
        c_sum     = es;
        c_cout    = ec;
        c_ovf     = eo;
        drive(1'b1, ia, ib, ic, iop);
        tick();
        use_const = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) tick();
        check("drain_empty", 128'(q.size()), 128'(0));
    endtask

    initial begin
        resetn    = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, OP_ADD);
        @(negedge clk);
        tick();
        tick();
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_sum",       128'(sum),       128'(0));
        check("rst_cout",      128'(cout),      128'(0));
        check("rst_ovf",       128'(ovf),       128'(0));
        resetn = 1'b1;
        #1;
        check("rst_in_ready",  128'(in_ready),  128'(1));
        tick();

        // Boundary vectors, issued back to back.
        directed('1, '0, 1'b1, OP_ADD, '0, 1'b1, 1'b0);
        directed(W'(5), W'(7), 1'b0, OP_SUB, {{(W-1){1'b1}}, 1'b0}, 1'b0, 1'b0);
        directed(W'(7), W'(5), 1'b0, OP_SUB, W'(2), 1'b1, 1'b0);
        directed({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, OP_ADD,
                 {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, OP_ADD);
        drain();

        // Ten back-to-back sets, then a six-cycle output stall with input pending.
        for (int i = 0; i < 10; i++) begin
            drive_rand(1'b1);
            tick();
        end
        drive_rand(1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        out_ready = 1'b1;
        tick();
        drive(1'b0, '0, '0, 1'b0, OP_ADD);
        drain();

        // Random valid/ready traffic.
        for (int i = 0; i < 200; i++) begin
            drive_rand(1'($urandom_range(0, 3) != 0));
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, OP_ADD);
        out_ready = 1'b1;
        drain();

        // Reset with three sets in flight: nothing stale may emerge.
        for (int i = 0; i < 3; i++) begin
            drive_rand(1'b1);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, OP_ADD);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("flush_out_valid", 128'(out_valid), 128'(0));
            tick();
        end
        drive_rand(1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, OP_ADD);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
